// File: rtl/dm_responder.sv
// Wait-state memory responder: accepts one request in IDLE, waits WAIT_CYC cycles,
// then issues a single-cycle ack with read data or an alignment error.
module dm_responder #(
  parameter int unsigned WAIT_CYC = 2,
  parameter int unsigned DEPTH_W  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        wr_byte,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic               we_q, byte_q;
  logic [DEPTH_W+1:0] addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        mem [2**DEPTH_W];

  logic [DEPTH_W-1:0] word_idx;
  logic [1:0]         lane;
  logic               misalign;

  assign word_idx = addr_q[DEPTH_W+1:2];
  assign lane     = addr_q[1:0];
  // Only a byte write may target a non-zero lane; everything else needs word alignment.
  assign misalign = !(we_q && byte_q) && (lane != 2'd0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_nxt   = 4'(WAIT_CYC);
          state_nxt = (WAIT_CYC == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          cnt_nxt   = '0;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && req) begin
      we_q    <= we;
      byte_q  <= wr_byte;
      addr_q  <= addr[DEPTH_W+1:0];
      wdata_q <= wdata;
    end
  end

  // Storage is never reset; a reset during RESP suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && state == RESP && we_q && !misalign) begin
      if (byte_q)
        mem[word_idx][8*lane +: 8] <= wdata_q[7:0];
      else
        mem[word_idx] <= wdata_q;
    end
  end

  always_comb begin
    busy  = (state != IDLE);
    ack   = (state == RESP);
    err   = ack && misalign;
    rdata = '0;
    if (ack && !we_q && !misalign)
      rdata = mem[word_idx];
  end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYC, default 2, meaning the number of wait cycles between request acceptance and response (legal range 0-15).
REQ-002 The block SHALL have parameter DEPTH_W, default 10, meaning the word-address width (2^DEPTH_W x 32-bit words, 4 KB at the default).
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req  input  1  request valid from the initiator; sampled only in IDLE.
REQ-006 Port we  input  1  1 = write, 0 = read.
REQ-007 Port wr_byte  input  1  1 = byte write (store-byte), 0 = word write; ignored on reads.
REQ-008 Port addr  input  32  byte address; bits [DEPTH_W+1:2] select the word, bits [1:0] select the byte lane, upper bits are ignored (aliasing).
REQ-009 Port wdata  input  32  write data; on a byte write only bits [7:0] are used.
REQ-010 Port ack  output  1  one-cycle response strobe.
REQ-011 Port rdata  output  32  read data, valid only while ack=1.
REQ-012 Port err  output  1  error flag, valid only while ack=1.
REQ-013 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-015 IDLE with req=1: latch addr, we, wr_byte and wdata; load the wait counter with WAIT_CYC; go to WAIT, or go directly to RESP if WAIT_CYC=0.
REQ-016 IDLE with req=0: stay in IDLE with no side effects.
REQ-017 WAIT: decrement the counter each cycle; go to RESP on the cycle the counter reaches 0, giving exactly WAIT_CYC cycles in WAIT.
REQ-018 RESP SHALL last exactly one cycle with ack=1, then return to IDLE unconditionally.
REQ-019 Latency from the req-sampling edge to ack high SHALL be WAIT_CYC+1 cycles; a new request SHALL be accepted no sooner than the cycle after RESP.
REQ-020 Inputs SHALL be ignored outside IDLE; the latched values alone define the transaction, and input changes during WAIT or RESP have no effect.
REQ-021 A word write SHALL commit all 32 bits at the clock edge ending RESP.
REQ-022 A byte write SHALL replace only the lane selected by addr[1:0] (little-endian: lane 0 = bits [7:0], lane 3 = bits [31:24]) and leave the other three bytes unchanged.
REQ-023 A read SHALL drive rdata with the full addressed word during RESP; rdata SHALL be 0 whenever ack=0.
REQ-024 A write response SHALL drive rdata = 0.
REQ-025 A word access (read, or write with wr_byte=0) with addr[1:0] != 0 SHALL give ack=1, err=1, rdata=0 and no memory update.
REQ-026 A byte write SHALL never set err.
REQ-027 Read-after-write: a read issued after a write's ack SHALL return the updated data.
REQ-028 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.

Reset
REQ-029 When reset=1 at a clock edge, the FSM SHALL go to IDLE with ack=0, err=0, rdata=0, busy=0 and the counter=0.
REQ-030 Reset SHALL take priority over every transition; reset asserted in WAIT or RESP SHALL abort the transaction, commit no write and produce no ack.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 req sampled on the same edge that reset is asserted SHALL be dropped.

Verification
REQ-033 Word write then read, WAIT_CYC=2: write addr=0x10, wdata=0xDEADBEEF -> ack 3 cycles after acceptance, err=0; read 0x10 -> rdata=0xDEADBEEF with ack.
REQ-034 Byte write: word 0x20=0x11223344, byte write addr=0x22, wdata=0x000000AA -> read 0x20 returns 0x11AA3344.
REQ-035 Misaligned access: word write addr=0x31, wdata=0xFFFFFFFF -> ack with err=1; read 0x30 returns the prior value unchanged.
REQ-036 Reset mid-operation: write 0x40 with 0x12345678 accepted, reset pulsed in WAIT -> no ack, busy=0 next cycle, read 0x40 returns the old value.
REQ-037 Zero wait and back-to-back, WAIT_CYC=0: req held high for 6 cycles -> ack on cycles 2, 4 and 6 only, with no overlap or loss of latched address.
REQ-038 Input stability: change addr and wdata during WAIT -> the committed location and data equal the values latched at acceptance.
